// File: rtl/input_overlay_compositor.sv
// input_overlay_compositor
// Addresses a registered d-pad mask ROM from the VGA scan position and lays the
// returned mask over the background stream in FILL_COLOR while the button is held.
// The raw button is synchronized, debounced and sampled once per frame so the
// overlay cannot change state partway down the screen.
// Pipeline: inputs -> (d1: ROM address, sideband) -> (d2: ROM data, sideband) -> rgb.
// Optional build macro INPUT_OVERLAY_OUTLINE_EN adds a one-pixel box outline in
// OUTLINE_COLOR that overrides mask and background.
module input_overlay_compositor #(
    parameter int          IMG_W           = 584,
    parameter int          IMG_H           = 167,
    parameter int          X0              = 28,
    parameter int          Y0              = 156,
    parameter logic [11:0] FILL_COLOR      = 12'hF80,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          V_LATCH         = 480
`ifdef INPUT_OVERLAY_OUTLINE_EN
    ,
    parameter logic [11:0] OUTLINE_COLOR   = 12'hFFF
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    input  logic [11:0] bg_rgb,
    input  logic        btn_raw,
    output logic [7:0]  rom_row,
    output logic [9:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb,
    output logic        pressed
);

    // Box bounds are compared at 11 bits so X0+IMG_W cannot wrap.
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + IMG_W);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + IMG_H);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [10:0] hc_ext;
    logic [10:0] vc_ext;
    logic        in_box;
    logic [7:0]  row_off;
    logic [9:0]  col_off;

    logic        in_box_d1;
    logic        video_on_d1;
    logic [11:0] bg_d1;
    logic        in_box_d2;
    logic        video_on_d2;
    logic [11:0] bg_d2;

    logic             btn_meta;
    logic             btn_sync;
    logic             btn_stable;
    logic [CNT_W-1:0] db_cnt;

    assign hc_ext  = {1'b0, hcount};
    assign vc_ext  = {1'b0, vcount};
    assign in_box  = (hc_ext >= X_LO) && (hc_ext < X_HI) &&
                     (vc_ext >= Y_LO) && (vc_ext < Y_HI);
    // Only the low 8 row bits reach the ROM; inside the box the offset fits.
    assign row_off = vcount[7:0] - 8'(Y0);
    assign col_off = hcount - 10'(X0);

`ifdef INPUT_OVERLAY_OUTLINE_EN
    logic on_edge;
    logic on_edge_d1;
    logic on_edge_d2;

    assign on_edge = in_box && ((row_off == 8'd0) || (row_off == 8'(IMG_H - 1)) ||
                                (col_off == 10'd0) || (col_off == 10'(IMG_W - 1)));

    // Carry the perimeter flag alongside the other sideband stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            on_edge_d1 <= 1'b0;
            on_edge_d2 <= 1'b0;
        end else begin
            on_edge_d1 <= on_edge;
            on_edge_d2 <= on_edge_d1;
        end
    end
`endif

    // Stage 1: ROM address plus sideband captured from the scan position.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_row     <= '0;
            rom_col     <= '0;
            in_box_d1   <= 1'b0;
            video_on_d1 <= 1'b0;
            bg_d1       <= '0;
        end else begin
            rom_row     <= in_box ? row_off : 8'd0;
            rom_col     <= in_box ? col_off : 10'd0;
            in_box_d1   <= in_box;
            video_on_d1 <= video_on;
            bg_d1       <= bg_rgb;
        end
    end

    // Stage 2: sideband waits out the ROM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_box_d2   <= 1'b0;
            video_on_d2 <= 1'b0;
            bg_d2       <= '0;
        end else begin
            in_box_d2   <= in_box_d1;
            video_on_d2 <= video_on_d1;
            bg_d2       <= bg_d1;
        end
    end

    // Stage 3: pick blank, outline, fill or background for the output pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= '0;
        end else if (!video_on_d2) begin
            rgb <= '0;
`ifdef INPUT_OVERLAY_OUTLINE_EN
        end else if (on_edge_d2) begin
            rgb <= OUTLINE_COLOR;
`endif
        end else if (in_box_d2 && pressed && (rom_data != 12'd0)) begin
            rgb <= FILL_COLOR;
        end else begin
            rgb <= bg_d2;
        end
    end

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // Debounce: accept a change only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt     <= '0;
            btn_stable <= 1'b0;
        end else if (btn_sync == btn_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            db_cnt     <= '0;
            btn_stable <= ~btn_stable;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    // Frame latch: the overlay state only changes at the start of line V_LATCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            pressed <= 1'b0;
        end else if ((vcount == 10'(V_LATCH)) && (hcount == 10'd0)) begin
            pressed <= btn_stable;
        end
    end

endmodule

// File: tb/tb_input_overlay_compositor.sv
// Testbench for input_overlay_compositor: directed test-plan cases with literal
// expectations, then randomized scan positions, button activity and resets,
// compared every cycle against a behavioural model.
module tb_input_overlay_compositor;

    localparam int          IMG_W   = 584;
    localparam int          IMG_H   = 167;
    localparam int          X0      = 28;
    localparam int          Y0      = 156;
    localparam logic [11:0] FILL    = 12'hF80;
    localparam int          N       = 8;
    localparam int          V_LATCH = 480;

    logic        clk;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        video_on;
    logic [11:0] bg_rgb;
    logic        btn_raw;
    logic [7:0]  rom_row;
    logic [9:0]  rom_col;
    logic [11:0] rom_data;
    logic [11:0] rgb;
    logic        pressed;

    int n_checks = 0;
    int n_errors = 0;

    input_overlay_compositor #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0),
        .FILL_COLOR(FILL), .DEBOUNCE_CYCLES(N), .V_LATCH(V_LATCH)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .video_on(video_on), .bg_rgb(bg_rgb), .btn_raw(btn_raw),
        .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
        .rgb(rgb), .pressed(pressed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mask content: (108,345) is set, (108,344) is transparent.
    function automatic logic [11:0] mask_at(input int r, input int c);
        int s;
        s = (r + c) % 3;
        if (s == 0) return 12'hFFF;
        if (s == 1) return 12'h001;
        return 12'h000;
    endfunction

    // Registered mask ROM, one cycle read latency.
    initial rom_data = 12'h000;
    always @(posedge clk) rom_data <= mask_at(int'(rom_row), int'(rom_col));

    typedef struct {
        int          hc;
        int          vc;
        logic        von;
        logic [11:0] bg;
        logic        rst;
    } smp_t;

    function automatic logic box_of(input int hc, input int vc);
        return (hc >= X0) && (hc < X0 + IMG_W) && (vc >= Y0) && (vc < Y0 + IMG_H);
    endfunction

    function automatic logic [11:0] composite(input smp_t s, input logic pr);
        int r;
        int c;
        r = s.vc - Y0;
        c = s.hc - X0;
        if (!s.von) return 12'h000;
`ifdef INPUT_OVERLAY_OUTLINE_EN
        if (box_of(s.hc, s.vc) && (r == 0 || r == IMG_H - 1 || c == 0 || c == IMG_W - 1))
            return 12'hFFF;
`endif
        if (box_of(s.hc, s.vc) && pr && mask_at(r, c) != 12'h000) return FILL;
        return s.bg;
    endfunction

    // Model state
    smp_t        p1, p2;
    logic        m_valid = 1'b0;
    logic        m_pressed, m_stable;
    logic        rp1, rp2;
    logic        sync_q[$];
    logic [11:0] e_rgb, e_row, e_col;

    task automatic model_step();
        smp_t cur;
        logic synced;
        logic all_diff;
        cur.hc  = int'(hcount);
        cur.vc  = int'(vcount);
        cur.von = video_on;
        cur.bg  = bg_rgb;
        cur.rst = reset;
        // Output pixel comes from the sample two edges back, blanked around any reset.
        if (cur.rst || p1.rst || p2.rst) e_rgb = 12'h000;
        else e_rgb = composite(p2, m_pressed);
        if (!cur.rst && box_of(cur.hc, cur.vc)) begin
            e_row = 12'((cur.vc - Y0) % 256);
            e_col = 12'(cur.hc - X0);
        end else begin
            e_row = 12'h000;
            e_col = 12'h000;
        end
        if (cur.rst) begin
            m_pressed = 1'b0;
            m_stable  = 1'b0;
            rp1 = 1'b0;
            rp2 = 1'b0;
            sync_q.delete();
            m_valid = 1'b1;
        end else begin
            if (cur.vc == V_LATCH && cur.hc == 0) m_pressed = m_stable;
            synced = rp2;
            rp2 = rp1;
            rp1 = btn_raw;
            sync_q.push_back(synced);
            if (sync_q.size() > N) void'(sync_q.pop_front());
            if (sync_q.size() == N) begin
                all_diff = 1'b1;
                foreach (sync_q[j]) if (sync_q[j] == m_stable) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable = ~m_stable;
                    sync_q.delete();
                end
            end
        end
        p2 = p1;
        p1 = cur;
    endtask

    initial begin
        p1.rst = 1'b1;
        p2.rst = 1'b1;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("rgb", rgb, e_rgb);
                check("rom_row", {4'h0, rom_row}, e_row);
                check("rom_col", {2'b00, rom_col}, e_col);
                check("pressed", {11'h000, pressed}, {11'h000, m_pressed});
            end
        end
    end

    task automatic drive(input int hc, input int vc, input logic von, input logic [11:0] bg);
        hcount   = 10'(hc);
        vcount   = 10'(vc);
        video_on = von;
        bg_rgb   = bg;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(100, 200, 1'b1, 12'h321);
    endtask

    int hold;
    int sel;
    int hc_r;
    int vc_r;

    initial begin
        reset = 1'b1;
        btn_raw = 1'b0;
        drive(100, 100, 1'b1, 12'h123);
        drive(100, 100, 1'b1, 12'h123);
        check("reset_rgb", rgb, 12'h000);
        check("reset_row", {4'h0, rom_row}, 12'd0);
        check("reset_col", {2'b00, rom_col}, 12'd0);
        check("reset_pressed", {11'h000, pressed}, 12'd0);
        reset = 1'b0;

        drive(373, 264, 1'b1, 12'h00F);
        check("addr_row", {4'h0, rom_row}, 12'd108);
        check("addr_col", {2'b00, rom_col}, 12'd345);
        drive(27, 264, 1'b1, 12'h0A5);
        check("outside_row", {4'h0, rom_row}, 12'd0);
        check("outside_col", {2'b00, rom_col}, 12'd0);
        drive(5, 5, 1'b1, 12'h000);
        check("unpressed_bg", rgb, 12'h00F);
        drive(5, 5, 1'b1, 12'h000);
        check("outside_bg", rgb, 12'h0A5);

        // Press; stable rises on row 200, overlay waits for the latch line.
        btn_raw = 1'b1;
        idle(N + 4);
        check("latch_hold", {11'h000, pressed}, 12'd0);
        drive(0, V_LATCH, 1'b1, 12'h000);
        check("latch_rise", {11'h000, pressed}, 12'd1);

        drive(373, 264, 1'b1, 12'h00F);
        drive(372, 264, 1'b1, 12'h00F);
        drive(5, 5, 1'b0, 12'h000);
        check("fill", rgb, 12'hF80);
        drive(5, 5, 1'b0, 12'h000);
        check("mask_clear", rgb, 12'h00F);

        drive(373, 264, 1'b0, 12'h00F);
        drive(5, 5, 1'b1, 12'h000);
        drive(5, 5, 1'b1, 12'h000);
        check("blank", rgb, 12'h000);

        drive(28, 200, 1'b1, 12'h0C0);
        drive(5, 5, 1'b1, 12'h000);
        drive(5, 5, 1'b1, 12'h000);
`ifdef INPUT_OVERLAY_OUTLINE_EN
        check("outline", rgb, 12'hFFF);
`else
        check("left_edge_bg", rgb, 12'h0C0);
`endif

        // Release, then a glitch two cycles too short to be accepted.
        btn_raw = 1'b0;
        idle(N + 4);
        drive(0, V_LATCH, 1'b1, 12'h000);
        check("release", {11'h000, pressed}, 12'd0);
        btn_raw = 1'b1;
        idle(N - 2);
        btn_raw = 1'b0;
        idle(N + 4);
        drive(0, V_LATCH, 1'b1, 12'h000);
        check("glitch", {11'h000, pressed}, 12'd0);

        // Reset mid-frame while pressed.
        btn_raw = 1'b1;
        idle(N + 4);
        drive(0, V_LATCH, 1'b1, 12'h000);
        check("repress", {11'h000, pressed}, 12'd1);
        drive(373, 264, 1'b1, 12'h00F);
        drive(374, 264, 1'b1, 12'h00F);
        reset = 1'b1;
        drive(375, 264, 1'b1, 12'h00F);
        check("midreset_rgb", rgb, 12'h000);
        check("midreset_row", {4'h0, rom_row}, 12'd0);
        check("midreset_col", {2'b00, rom_col}, 12'd0);
        check("midreset_pressed", {11'h000, pressed}, 12'd0);
        reset = 1'b0;

        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                btn_raw = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 20));
            end
            hold--;
            reset = ($urandom_range(0, 499) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                hc_r = 0;
                vc_r = V_LATCH;
            end else if (sel < 7) begin
                hc_r = int'($urandom_range(20, 620));
                vc_r = int'($urandom_range(150, 330));
            end else begin
                hc_r = int'($urandom_range(0, 1023));
                vc_r = int'($urandom_range(0, 1023));
            end
            drive(hc_r, vc_r, ($urandom_range(0, 3) != 0), 12'($urandom));
        end
        reset = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
